// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_unit : PC register, 1-cycle-latency instruction fetch and a
//                 DEPTH-entry instruction queue with redirect/irq/exc flush.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {1'b1, {(XLEN-1){1'b0}}},
  parameter logic [XLEN-1:0] IRQ_VEC  = {1'b1, (XLEN-1)'(4)},
  parameter logic [XLEN-1:0] EXC_VEC  = {1'b1, (XLEN-1)'(8)}
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pcp4,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            irq,
  input  logic            exc,
  output logic [XLEN-1:0] epc,
  output logic            kmode
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW        = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            run;

  logic [31:0]     q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            irq_take;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] next_pc;
  logic            pop;
  logic            push;
  logic [CW-1:0]   credit_used;

  assign kmode    = fetch_pc[XLEN-1];
  assign irq_take = irq & ~kmode;
  assign flush    = exc | irq_take | redir_valid;

  // User mode cannot raise the kernel bit through a redirect.
  assign redir_pc = {redir_target[XLEN-1] & kmode, redir_target[XLEN-2:0]} & WORD_MASK;

  always_comb begin
    if (exc) begin
      flush_pc = EXC_VEC;
    end else if (irq_take) begin
      flush_pc = IRQ_VEC;
    end else begin
      flush_pc = redir_pc;
    end
  end

  assign next_pc = {fetch_pc[XLEN-1], fetch_pc[XLEN-2:0] + (XLEN-1)'(4)};

  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight & ~flush;

  // Slots committed after this cycle: current entries minus the pop plus the returning word.
  assign credit_used = count - CW'(pop) + CW'(inflight);
  assign imem_req    = run & ~flush & (credit_used < DEPTH_C);
  assign imem_addr   = {1'b0, fetch_pc[XLEN-2:0]};

  assign inst_data = inst_valid ? q_data[rd_ptr] : 32'd0;
  assign inst_pc   = inst_valid ? q_pc[rd_ptr] : '0;
  assign inst_pcp4 = inst_valid ? (q_pc[rd_ptr] + XLEN'(4)) : '0;

  always_comb begin
    if (inst_valid) begin
      epc = q_pc[rd_ptr];
    end else if (inflight) begin
      epc = inflight_pc;
    end else begin
      epc = fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      run         <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
      end
      if (flush) begin
        fetch_pc <= flush_pc;
      end else if (imem_req) begin
        fetch_pc <= next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      q_data[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count == DEPTH_C)));

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the single-cycle PC logic: PC register, pipelined instruction fetch and an instruction queue, for the pipelined MIPS core.
- Issues word fetches to a synchronous-read instruction ROM with fixed 1-cycle latency.
- Buffers returned instructions in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Handles redirects (branch/jump/jr), interrupt and exception vectoring, kernel-mode bit PC[31], and flush of buffered and in-flight fetches.

Parameters:
XLEN, 32, datapath/PC width (must be >= 8)
DEPTH, 4, instruction queue entries (power of 2, >= 2)
RESET_PC, 32'h80000000, PC after reset (kernel mode)
IRQ_VEC, 32'h80000004, interrupt vector
EXC_VEC, 32'h80000008, exception (undefined instruction) vector

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
imem_req  out  1  fetch request this cycle
imem_addr  out  XLEN  {1'b0, fetch_pc[XLEN-2:0]}
imem_rdata  in  32  instruction, valid exactly 1 cycle after imem_req
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head
inst_data  out  32  head instruction
inst_pc  out  XLEN  head PC (bit XLEN-1 = kernel bit)
inst_pcp4  out  XLEN  inst_pc + 4
redir_valid  in  1  branch/jump/jr redirect
redir_target  in  XLEN  redirect target
irq  in  1  interrupt request (level)
exc  in  1  exception request (pulse)
epc  out  XLEN  PC of oldest non-retired fetched instruction
kmode  out  1  current fetch_pc[XLEN-1]

Behaviour:
- Reset (reset==0 at clk edge): fetch_pc=RESET_PC; queue empty; in-flight flag cleared. Outputs: imem_req=0, inst_valid=0, inst_data=0, inst_pc=0, inst_pcp4=0, epc=RESET_PC, kmode=1. imem_req stays 0 in the first cycle after reset is released.
- Credit rule: imem_req=1 iff occupancy + inflight < DEPTH, with no flush this cycle. The occupancy term counts the current pop (a same-cycle pop frees its slot). On request, fetch_pc += 4 (wraps modulo 2^(XLEN-1); kernel bit is preserved).
- Response: the cycle after a request, imem_rdata is pushed with its PC unless killed by a flush. The queue never overflows; an overflow is a design error and triggers an assertion.
- Pop: inst_valid && inst_ready. Push and pop in the same cycle are both performed, including when the queue is full (pop first) or empty (the new entry is not bypassed; it becomes visible next cycle).
- Flush sources, priority exc > irq > redirect:
  - exc: new fetch_pc = EXC_VEC.
  - irq: new fetch_pc = IRQ_VEC. irq is ignored when kmode=1.
  - redirect: new fetch_pc = {redir_target[XLEN-1] & kmode, redir_target[XLEN-2:0]}. User mode can never enter kernel space via redirect; kernel mode may leave it.
- Flush effect:
  - The queue is emptied in the same edge; inst_valid=0 the next cycle.
  - The in-flight response returning next cycle is discarded.
  - A pop occurring in the flush cycle still counts as accepted.
  - The first request at the new PC is issued the cycle after the flush.
- epc = head PC when the queue is non-empty, else the PC of the in-flight fetch if any, else fetch_pc. It is sampled by the core at irq acceptance (the core writes epc to $26 as the return address).
- Redirect target bits [1:0] are ignored (forced to 0).
- Reset has precedence over everything; asserting it mid-flush or mid-fetch gives the reset state exactly.

Test Plan:
- Reset then inst_ready=1 with ROM[i]=i: imem_req at cycles 1,2,3…; addresses 0x0,0x4,0x8; inst_pc 0x80000000, 0x80000004, … every cycle from cycle 3.
- inst_ready=0 for 10 cycles: exactly DEPTH=4 requests, then imem_req=0; release → queue drains in order, no lost or duplicated PCs.
- Queue full, kmode=0, redir_valid with target 0x80000040: next fetch address 0x40, inst_pc=0x00000040 (kernel bit masked); old entries and the in-flight word never appear.
- Same cycle exc=1, irq=1, redir_valid=1: fetch_pc=0x80000008; irq with kmode=1 alone → no flush, stream continues.
- User stream at PC 0x100, queue holding 0x100,0x104, irq=1: epc=0x100, next inst_pc=0x80000004.
- Assert reset for one cycle mid-stream with queue half full: all outputs at reset values; restart fetch from 0x80000000.
